// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared response-stage type and legal parameter ranges
package mem_responder_pkg;

  localparam int unsigned LatencyMin   = 1;
  localparam int unsigned LatencyMax   = 8;
  localparam int unsigned GntPeriodMin = 1;
  localparam int unsigned GntPeriodMax = 15;
  localparam int unsigned PhaseWidth   = 4;
  localparam int unsigned DefDataWidth = 32;

  typedef struct packed {
    logic                    valid;
    logic                    err;
    logic [DefDataWidth-1:0] data;
  } rsp_stage_t;

  // Out-of-range parameters saturate instead of producing a broken pipeline or counter.
  function automatic int unsigned clamp_param(int unsigned value, int unsigned lo, int unsigned hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// rtl/mem_rsp_pipe.sv - fixed-depth response delay line, one stage per cycle
module mem_rsp_pipe
  import mem_responder_pkg::*;
#(
  parameter int unsigned Depth   = 1,
  parameter type         stage_t = rsp_stage_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  stage_t stage_i,
  output stage_t stage_o
);

  stage_t [Depth-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = stage_i;
    for (int i = 1; i < int'(Depth); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign stage_o = pipe_q[Depth-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - throttled-grant memory responder with fixed response latency
// Define MEM_RESPONDER_ERR_EN to flag requests with address bits above the word index.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 256,
  parameter int unsigned Latency   = 1,
  parameter int unsigned GntPeriod = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o
);

  localparam int unsigned LatencyEff   = clamp_param(Latency, LatencyMin, LatencyMax);
  localparam int unsigned GntPeriodEff = clamp_param(GntPeriod, GntPeriodMin, GntPeriodMax);
  localparam int unsigned BeWidth      = DataWidth / 8;
  localparam int unsigned OffWidth     = $clog2(BeWidth);
  localparam int unsigned IdxWidth     = $clog2(NumWords);
  localparam int unsigned UpperLsb     = OffWidth + IdxWidth;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [DataWidth-1:0] data;
  } stage_t;

  logic [PhaseWidth-1:0]              phase_q, phase_d;
  logic [NumWords-1:0][DataWidth-1:0] mem_q, mem_d;
  logic [IdxWidth-1:0]                idx;
  logic                               granted;
  logic                               addr_err;
  logic                               wr_en;
  logic                               unused_bits;
  stage_t                             stage_in;
  stage_t                             stage_out;

  // Grant depends only on the phase register, never on req_i.
  assign gnt_o   = (phase_q == '0);
  assign granted = req_i & gnt_o;
  assign idx     = addr_i[OffWidth +: IdxWidth];

`ifdef MEM_RESPONDER_ERR_EN
  if (AddrWidth > UpperLsb) begin : g_addr_hi
    assign addr_err = |addr_i[AddrWidth-1:UpperLsb];
  end else begin : g_no_addr_hi
    assign addr_err = 1'b0;
  end
`else
  assign addr_err = 1'b0;
`endif

  assign wr_en = granted & we_i & ~addr_err;

  always_comb begin
    phase_d = phase_q + 1'b1;
    if (phase_q >= PhaseWidth'(GntPeriodEff - 1)) begin
      phase_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (be_i[b]) begin
          mem_d[idx][8*b +: 8] = wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the array before this edge's write lands; writes answer with zero data.
  always_comb begin
    stage_in = '0;
    if (granted) begin
      stage_in.valid = 1'b1;
      stage_in.err   = addr_err;
      if (!we_i && !addr_err) begin
        stage_in.data = mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      mem_q   <= '0;
    end else begin
      phase_q <= phase_d;
      mem_q   <= mem_d;
    end
  end

  mem_rsp_pipe #(
    .Depth   (LatencyEff),
    .stage_t (stage_t)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stage_i (stage_in),
    .stage_o (stage_out)
  );

  assign rvalid_o = stage_out.valid;
  assign rdata_o  = stage_out.data;

`ifdef MEM_RESPONDER_ERR_EN
  assign err_o = stage_out.err;
  assign unused_bits = ^addr_i;
`else
  assign err_o = 1'b0;
  assign unused_bits = ^{addr_i, stage_out.err};
`endif

endmodule
